// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit that holds the architectural HI/LO registers.
// One step per cycle for WIDTH cycles, then a single sign-fix cycle that commits HI/LO.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [5:0]       mdFunct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam int         CW      = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d, busy_q, busy_d, done_q, done_d;

  logic               is_mul_op, is_div_op, is_signed_op, accept;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_mul_op    = (mdFunct == F_MULT) || (mdFunct == F_MULTU);
  assign is_div_op    = (mdFunct == F_DIV)  || (mdFunct == F_DIVU);
  assign is_signed_op = (mdFunct == F_MULT) || (mdFunct == F_DIV);
  // cancel in IDLE swallows a same-cycle start of any kind
  assign accept       = start && !cancel;

  // Multiply: add multiplicand into the high half, then shift the whole product right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
  // Divide: remainder lives in acc high half, quotient bits shift into the low half.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};

  assign prod_fix = neg_q     ? -acc_q                     : acc_q;
  assign quo_fix  = neg_q     ? -acc_q[WIDTH-1:0]          : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]    : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every register, datapath included, is reset so a mid-op reset leaves no stale partial state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && (is_mul_op || is_div_op)) state_d = S_CALC;
      S_CALC: begin
        if (cancel)                           state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))     state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latches are inferred.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (accept && (is_mul_op || is_div_op)) begin
          a_d        = (is_signed_op && opA[WIDTH-1]) ? -opA : opA;
          b_d        = (is_signed_op && opB[WIDTH-1]) ? -opB : opB;
          neg_d      = is_signed_op && (opA[WIDTH-1] ^ opB[WIDTH-1]);
          rem_neg_d  = is_signed_op && opA[WIDTH-1];
          is_div_d   = is_div_op;
          div_zero_d = is_div_op && (opB == '0);
          acc_d      = '0;
          cnt_d      = '0;
        end else if (accept && (mdFunct == F_MTHI)) begin
          hi_d = opA;
        end else if (accept && (mdFunct == F_MTLO)) begin
          lo_d = opA;
        end
      end
      S_CALC: begin
        if (!cancel) begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_q) begin
            acc_d = {(div_diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
            a_d   = a_q << 1;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
          end
        end
      end
      S_FIX: begin
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else begin
            // Divide by zero yields all-ones quotient; remainder restores to opA itself.
            hi_d = rem_fix;
            lo_d = div_zero_q ? '1 : quo_fix;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
